// File: rtl/bcd_pkg.sv
// Shared BCD arithmetic types: digit width, digit limit, serial-subtractor state encoding.
// Latency: none (types and a pure function only).
// Backpressure: not applicable.
package bcd_pkg;

    localparam int          BCD_W   = 4;
    localparam logic [3:0]  BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // A nibble is a legal decimal digit only when it is 0..9.
    function automatic logic bcd_valid(input logic [BCD_W-1:0] d);
        return (d <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// Single-digit BCD subtract with borrow: d = x - y - bin, corrected back into 0..9.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module bcd_digit_sub
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] x,
    input  logic [BCD_W-1:0] y,
    input  logic             bin,
    output logic [BCD_W-1:0] d,
    output logic             bout
);

    logic [BCD_W:0] t;

    // 5-bit signed difference; a negative result wraps into range by adding ten.
    always_comb begin
        t    = {1'b0, x} - {1'b0, y} - {{BCD_W{1'b0}}, bin};
        bout = t[BCD_W];
        d    = t[BCD_W] ? (t[BCD_W-1:0] + 4'd10) : t[BCD_W-1:0];
    end

endmodule

// File: rtl/bcd_serial_sub.sv
// Serial |a-b| on packed BCD, one digit per clock LSD first, with a ten's-complement fix pass when a<b.
// Latency: done at cycle 1 (bad digit), DIGITS+1 (a>=b) or 2*DIGITS+1 (a<b) after the start cycle.
// Backpressure: start is only honoured in IDLE; requests while busy or done are dropped.
module bcd_serial_sub
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [BCD_W*DIGITS-1:0] a,
    input  logic [BCD_W*DIGITS-1:0] b,
    output logic                    busy,
    output logic                    done,
    output logic [BCD_W*DIGITS-1:0] diff,
    output logic                    neg,
    output logic                    err
);

    localparam int             W    = BCD_W * DIGITS;
    localparam int             IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0]  LAST = IW'(DIGITS - 1);

    state_t         state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic           borrow_q, borrow_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   diff_q, diff_d;
    logic           neg_q, neg_d;
    logic           err_q, err_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic [BCD_W-1:0] a_sel, b_sel, diff_sel;
    logic [BCD_W-1:0] op_x, op_y, dig_d;
    logic             dig_bout;
    logic             in_valid;

    // Pick the current digit of each latched operand and of the partial result.
    always_comb begin
        a_sel    = '0;
        b_sel    = '0;
        diff_sel = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                a_sel    = a_q[k*BCD_W +: BCD_W];
                b_sel    = b_q[k*BCD_W +: BCD_W];
                diff_sel = diff_q[k*BCD_W +: BCD_W];
            end
        end
    end

    // SUB feeds a_i - b_i; FIX negates the stored digit as 0 - diff_i.
    always_comb begin
        op_x = (state_q == FIX) ? '0 : a_sel;
        op_y = (state_q == FIX) ? diff_sel : b_sel;
    end

    bcd_digit_sub u_digit (
        .x    (op_x),
        .y    (op_y),
        .bin  (borrow_q),
        .d    (dig_d),
        .bout (dig_bout)
    );

    // Operands are screened on the live inputs so a bad request never enters SUB.
    always_comb begin
        in_valid = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (!bcd_valid(a[k*BCD_W +: BCD_W]) || !bcd_valid(b[k*BCD_W +: BCD_W])) begin
                in_valid = 1'b0;
            end
        end
    end

    // Next-state and datapath updates for the IDLE/SUB/FIX/DONE sequence.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        borrow_d = borrow_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        neg_d    = neg_q;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d      = a;
                    b_d      = b;
                    diff_d   = '0;
                    neg_d    = 1'b0;
                    err_d    = 1'b0;
                    borrow_d = 1'b0;
                    idx_d    = '0;
                    if (!in_valid) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = SUB;
                    end
                end
            end
            SUB, FIX: begin
                for (int k = 0; k < DIGITS; k++) begin
                    if (idx_q == IW'(k)) begin
                        diff_d[k*BCD_W +: BCD_W] = dig_d;
                    end
                end
                borrow_d = dig_bout;
                if (idx_q == LAST) begin
                    idx_d    = '0;
                    borrow_d = 1'b0;
                    if (state_q == SUB && dig_bout) begin
                        // Result went below zero: it now holds 10^DIGITS + a - b, so negate it.
                        neg_d   = 1'b1;
                        state_d = FIX;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == SUB) || (state_d == FIX);
        done_d = (state_d == DONE);
    end

    // State and registered outputs; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            borrow_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            neg_q    <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            borrow_q <= borrow_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            neg_q    <= neg_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign neg  = neg_q;
    assign err  = err_q;

endmodule

// File: tb/tb_bcd_serial_sub.sv
// Directed bench for bcd_serial_sub with an expected-result queue popped on done.
// Latency: checks done cycle against the expected count from the start cycle.
// Backpressure: exercises ignored start during SUB and reset abort during FIX.
module tb_bcd_serial_sub;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         neg;
        logic         err;
        logic [7:0]   lat;
    } exp_t;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         neg;
    logic         err;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    bcd_serial_sub #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .neg   (neg),
        .err   (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request, track it cycle by cycle, compare against the queued expectation.
    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] ed, input logic en, input logic ee,
                          input int lat, input bit repulse);
        exp_t e;
        exp_t got;
        int   cyc;
        bit   busy_ok;
        bit   seen;
        e.diff = ed;
        e.neg  = en;
        e.err  = ee;
        e.lat  = lat[7:0];
        sb_q.push_back(e);

        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1; busy_ok = 1'b1; seen = 1'b0;
        got = '0;
        while (!seen && cyc <= 40) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                got  = sb_q.pop_front();
                if (busy !== 1'b0) busy_ok = 1'b0;
            end else begin
                if (busy !== 1'b1) busy_ok = 1'b0;
                if (repulse && cyc == 2) begin
                    start = 1'b1; a = 16'h9999; b = 16'h0000;
                end
                if (repulse && cyc == 3) start = 1'b0;
                @(posedge clk); #1;
                cyc++;
            end
        end
        start = 1'b0;
        check({tag, " done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({tag, " diff"},    32'(diff), 32'(got.diff));
            check({tag, " neg"},     32'(neg),  32'(got.neg));
            check({tag, " err"},     32'(err),  32'(got.err));
            check({tag, " latency"}, 32'(cyc),  32'(got.lat));
            check({tag, " busy"},    32'(busy_ok), 32'd1);
            @(posedge clk); #1;
            check({tag, " done_pulse"}, 32'(done), 32'd0);
            check({tag, " diff_hold"},  32'(diff), 32'(got.diff));
        end
    endtask

    initial begin
        int done_cnt;

        // Reset values while rst_n is held low.
        #1;
        check("reset_outs", {15'd0, busy, done, diff, neg, err}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("plain",    16'h5234, 16'h1234, 16'h4000, 1'b0, 1'b0, 5, 1'b0);
        run_op("chain",    16'h1000, 16'h0001, 16'h0999, 1'b0, 1'b0, 5, 1'b0);
        run_op("negative", 16'h0012, 16'h0345, 16'h0333, 1'b1, 1'b0, 9, 1'b0);
        run_op("equal",    16'h9999, 16'h9999, 16'h0000, 1'b0, 1'b0, 5, 1'b0);
        run_op("neg_one",  16'h0000, 16'h0001, 16'h0001, 1'b1, 1'b0, 9, 1'b0);
        run_op("bad_dig",  16'h00A1, 16'h0000, 16'h0000, 1'b0, 1'b1, 1, 1'b0);
        run_op("repulse",  16'h5234, 16'h1234, 16'h4000, 1'b0, 1'b0, 5, 1'b1);
        run_op("bad_b",    16'h0005, 16'hF000, 16'h0000, 1'b0, 1'b1, 1, 1'b0);

        // Reset in the middle of FIX must clear everything at once and drop the result.
        @(negedge clk);
        a = 16'h0012; b = 16'h0345; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("pre_reset_busy", 32'(busy), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_outs", {15'd0, busy, done, diff, neg, err}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) done_cnt++;
        end
        check("no_done_after_abort", 32'(done_cnt), 32'd0);

        run_op("post_reset", 16'h0003, 16'h0001, 16'h0002, 1'b0, 1'b0, 5, 1'b0);

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
